// File: rtl/ah_demux_pkg.sv
// rtl/ah_demux_pkg.sv - shared types and helpers for the packet-aware demux
package ah_demux_pkg;

  // Packet routing state: waiting for a first beat, forwarding, or sinking
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } state_e;

  // Select width never collapses to zero bits
  function automatic int clog2_min1(input int n);
    int r;
    r = (n <= 2) ? 1 : $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/ah_skid_buf_2e.sv
// rtl/ah_skid_buf_2e.sv - two-entry registered skid buffer, FIFO order
module ah_skid_buf_2e #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  // Ready and valid come straight from the occupancy register, cutting the paths
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next occupancy and storage; an empty buffer never bypasses, so output stays registered
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  // Storage registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/ah_demux_pkt_skid.sv
// rtl/ah_demux_pkt_skid.sv - packet-locked valid/ready demux with per-egress skid buffers
module ah_demux_pkt_skid
  import ah_demux_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int N_EGR  = 9,
  parameter int SEL_W  = clog2_min1(N_EGR),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        select,
  input  logic [DATA_W-1:0]       ing_data,
  input  logic                    ing_last,
  input  logic                    ing_valid,
  output logic                    ing_ready,
  output logic [N_EGR*DATA_W-1:0] egr_data,
  output logic [N_EGR-1:0]        egr_last,
  output logic [N_EGR-1:0]        egr_valid,
  input  logic [N_EGR-1:0]        egr_ready,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    sel_err
);

  localparam int W = DATA_W + 1;
  localparam logic [SEL_W:0] N_EGR_L = (SEL_W+1)'(N_EGR);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] route_q, route_d, route;
  logic             route_valid, sel_in_range, sel_ready;
  logic             accepted, drop_beat;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             sel_err_q, sel_err_d;
  logic [N_EGR-1:0] skid_in_valid, skid_in_ready;

  assign sel_in_range = ({1'b0, select} < N_EGR_L);

  // Current route: live select on a first beat, latched route inside a packet
  always_comb begin
    route       = route_q;
    route_valid = 1'b0;
    case (state_q)
      IDLE: begin
        route       = select;
        route_valid = sel_in_range;
      end
      LOCKED:  route_valid = 1'b1;
      default: route_valid = 1'b0;
    endcase
  end

  // Only the routed skid sees a push; its ready is the only one that reaches ingress
  always_comb begin
    sel_ready     = 1'b0;
    skid_in_valid = '0;
    for (int i = 0; i < N_EGR; i++) begin
      if (route_valid && (route == SEL_W'(i))) begin
        sel_ready        = skid_in_ready[i];
        skid_in_valid[i] = ing_valid;
      end
    end
  end

  assign ing_ready = rst_n & (route_valid ? sel_ready : 1'b1);
  assign accepted  = ing_valid & ing_ready;
  assign drop_beat = accepted & ~route_valid;

  // Packet FSM, route latch and drop accounting next-state
  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    drop_cnt_d = drop_cnt_q;
    sel_err_d  = drop_beat && (state_q == IDLE);
    if (drop_beat && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (accepted) begin
      if (ing_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = sel_in_range ? LOCKED : DROP;
        route_d = select;
      end
    end
  end

  // FSM and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      route_q    <= '0;
      drop_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      drop_cnt_q <= drop_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign sel_err  = sel_err_q;

  for (genvar g = 0; g < N_EGR; g++) begin : g_egr
    logic [W-1:0] out_w;

    ah_skid_buf_2e #(.W(W)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (skid_in_valid[g]),
      .in_data  ({ing_last, ing_data}),
      .in_ready (skid_in_ready[g]),
      .out_valid(egr_valid[g]),
      .out_data (out_w),
      .out_ready(egr_ready[g])
    );

    assign egr_last[g]                   = out_w[W-1];
    assign egr_data[g*DATA_W +: DATA_W] = out_w[DATA_W-1:0];
  end

endmodule

// File: tb/tb_ah_demux_pkt_skid.sv
// tb/tb_ah_demux_pkt_skid.sv - self-checking bench for ah_demux_pkt_skid
module tb_ah_demux_pkt_skid;

  localparam int DW = 19;
  localparam int NE = 9;
  localparam int SW = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SW-1:0]   select;
  logic [DW-1:0]   ing_data;
  logic            ing_last;
  logic            ing_valid;
  logic            ing_ready;
  logic [NE*DW-1:0] egr_data;
  logic [NE-1:0]   egr_last;
  logic [NE-1:0]   egr_valid;
  logic [NE-1:0]   egr_ready;
  logic [CW-1:0]   drop_cnt;
  logic            sel_err;

  int checks = 0;
  int errors = 0;

  typedef logic [DW:0] beat_t;
  beat_t sbq [NE][$];
  int    m_state = 0;
  int    m_route = 0;
  int    m_drop  = 0;
  int    exp_sel_err = 0;
  int    r;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    int            egr;
    logic [NE-1:0] exp_valid;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  ah_demux_pkt_skid #(.DATA_W(DW), .N_EGR(NE), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .select   (select),
    .ing_data (ing_data),
    .ing_last (ing_last),
    .ing_valid(ing_valid),
    .ing_ready(ing_ready),
    .egr_data (egr_data),
    .egr_last (egr_last),
    .egr_valid(egr_valid),
    .egr_ready(egr_ready),
    .drop_cnt (drop_cnt),
    .sel_err  (sel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat and hold it until accepted; returns with inputs idle at posedge+1
  task automatic send(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic l, output int waits);
    waits     = 0;
    select    = s;
    ing_data  = d;
    ing_last  = l;
    ing_valid = 1'b1;
    @(negedge clk);
    while (!ing_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!ing_ready) chk("send_timeout", ing_ready, 1);
    @(posedge clk);
    #1;
    ing_valid = 1'b0;
  endtask

  // Scoreboard: push expected beats on ingress handshake, compare on egress
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) sbq[i].delete();
      m_state     = 0;
      m_drop      = 0;
      exp_sel_err = 0;
    end else begin
      chk("sel_err", sel_err, exp_sel_err);
      chk("drop_cnt", drop_cnt, m_drop);
      for (int i = 0; i < NE; i++) begin
        if (egr_valid[i]) begin
          if (sbq[i].size() == 0) begin
            chk($sformatf("egr%0d_unexpected_valid", i), egr_valid[i], 0);
          end else begin
            chk($sformatf("egr%0d_beat", i), {egr_last[i], egr_data[i*DW +: DW]}, sbq[i][0]);
            if (egr_ready[i]) void'(sbq[i].pop_front());
          end
        end
      end
      exp_sel_err = 0;
      if (ing_valid && ing_ready) begin
        r = (m_state == 0) ? int'(select) : m_route;
        if (r < NE) begin
          sbq[r].push_back({ing_last, ing_data});
        end else begin
          if (m_drop < 65535) m_drop++;
          if (m_state == 0) exp_sel_err = 1;
        end
        if (ing_last) m_state = 0;
        else if (m_state == 0) begin
          m_state = (r < NE) ? 1 : 2;
          m_route = r;
        end
      end
    end
  end

  initial begin
    int w;
    vecs[0] = '{4'd0, 19'h00010, 0, 9'h001};
    vecs[1] = '{4'd1, 19'h00011, 1, 9'h002};
    vecs[2] = '{4'd8, 19'h00012, 8, 9'h100};
    vecs[3] = '{4'd0, 19'h00013, 0, 9'h001};

    rst_n = 1'b1; select = '0; ing_data = '0; ing_last = 1'b0; ing_valid = 1'b0; egr_ready = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ing_ready", ing_ready, 0);
    chk("rst_egr_valid", egr_valid, 0);
    chk("rst_egr_last", egr_last, 0);
    chk("rst_egr_data_zero", (egr_data == '0), 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_sel_err", sel_err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Route locks on the first beat; mid-packet select change is ignored
    send(4'd4, 19'h00001, 1'b0, w);
    chk("t1_lat_valid4", egr_valid[4], 1);
    chk("t1_lat_data4", egr_data[4*DW +: DW], 19'h00001);
    chk("t1_egr7_idle", egr_valid[7], 0);
    send(4'd7, 19'h00002, 1'b0, w);
    send(4'd7, 19'h00003, 1'b1, w);
    chk("t1_last_valid4", egr_valid[4], 1);
    chk("t1_last4", egr_last[4], 1);
    chk("t1_egr7_idle2", egr_valid[7], 0);

    // Out-of-range select drops the whole packet
    send(4'd12, 19'h00055, 1'b0, w);
    chk("t2_ready_first", w, 0);
    chk("t2_sel_err", sel_err, 1);
    chk("t2_cnt1", drop_cnt, 1);
    send(4'd3, 19'h00056, 1'b1, w);
    chk("t2_ready_second", w, 0);
    chk("t2_sel_err_once", sel_err, 0);
    chk("t2_cnt2", drop_cnt, 2);
    chk("t2_no_valid", egr_valid, 0);

    // Back-to-back single-beat packets, one per cycle
    for (int k = 0; k < 4; k++) begin
      send(vecs[k].sel, vecs[k].data, 1'b1, w);
      chk("t4_ready", w, 0);
      chk("t4_valid", egr_valid, vecs[k].exp_valid);
      chk("t4_data", egr_data[vecs[k].egr*DW +: DW], vecs[k].data);
    end

    // Backpressure on egr2: two beats fit, then ingress stalls, then drains in order
    egr_ready[2] = 1'b0;
    send(4'd2, 19'h00021, 1'b0, w);
    send(4'd9, 19'h00022, 1'b0, w);
    chk("t3_second_ready", w, 0);
    select = 4'd2; ing_data = 19'h00023; ing_last = 1'b0; ing_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_backpressure", ing_ready, 0);
    end
    chk("t3_egr2_held", egr_valid[2], 1);
    @(posedge clk);
    #1;
    egr_ready[2] = 1'b1;
    send(4'd2, 19'h00023, 1'b0, w);
    send(4'd2, 19'h00024, 1'b1, w);

    // Drop counter saturation
    chk("t6_cnt_start", drop_cnt, 2);
    for (int k = 0; k < 65532; k++) send(4'd15, DW'(k), 1'b0, w);
    chk("t6_cnt_fffe", drop_cnt, 16'hFFFE);
    send(4'd15, 19'h00001, 1'b0, w);
    chk("t6_cnt_ffff", drop_cnt, 16'hFFFF);
    send(4'd15, 19'h00002, 1'b0, w);
    send(4'd15, 19'h00003, 1'b1, w);
    chk("t6_cnt_sat", drop_cnt, 16'hFFFF);

    // Asynchronous reset with egr5 full mid-packet
    egr_ready[5] = 1'b0;
    send(4'd5, 19'h00051, 1'b0, w);
    send(4'd5, 19'h00052, 1'b0, w);
    select = 4'd5; ing_data = 19'h00053; ing_last = 1'b0; ing_valid = 1'b1;
    @(negedge clk);
    chk("t5_full", ing_ready, 0);
    chk("t5_egr5_valid", egr_valid[5], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", egr_valid, 0);
    chk("t5_async_ready", ing_ready, 0);
    chk("t5_async_data", (egr_data == '0), 1);
    chk("t5_async_cnt", drop_cnt, 0);
    ing_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    egr_ready = '1;
    @(posedge clk);
    #1;
    send(4'd3, 19'h00061, 1'b1, w);
    chk("t5_new_route", egr_valid, 9'h008);
    chk("t5_new_data", egr_data[3*DW +: DW], 19'h00061);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) chk($sformatf("drain_egr%0d", i), sbq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
